// File: rtl/sweep_pkg.sv
// Shared types and default widths for the sweep/peak-tracking sequencer.
package sweep_pkg;

  localparam int unsigned DW_DEF      = 12;
  localparam int unsigned POS_W_DEF   = 8;
  localparam int unsigned LSB_IGN_DEF = 2;
  // Width of the noise-masked sample used in the peak comparison.
  localparam int unsigned CMP_W       = DW_DEF - LSB_IGN_DEF;

  typedef enum logic [3:0] {
    StIdle,
    StMove,
    StSettle,
    StReq,
    StWait,
    StCmp,
    StReturn,
    StRsettle,
    StFin
  } state_e;

endpackage

// File: rtl/sweep_timer.sv
// Loadable down-counter with zero flag; shared by the settle and ADC-timeout waits.
module sweep_timer #(
  parameter int unsigned W = 10
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sweep_peak_ctrl.sv
// Servo sweep sequencer: settles at each position, samples the ADC, tracks the
// masked maximum and its position, then parks the servo at the best position.
module sweep_peak_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned POS_W       = POS_W_DEF,
  parameter int unsigned POS_MIN     = 0,
  parameter int unsigned POS_MAX     = 180,
  parameter int unsigned POS_STEP    = 10,
  parameter int unsigned SETTLE_CYC  = 1000,
  parameter int unsigned ADC_TIMEOUT = 255,
  parameter int unsigned LSB_IGN     = LSB_IGN_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [DW-1:0]    ADC_DATA,
  input  logic             ADC_VALID,
  output logic             ADC_REQ,
  output logic [POS_W-1:0] SERVO_POS,
  output logic             GT,
  output logic [DW-1:0]    PV,
  output logic [DW-1:0]    MAX_V,
  output logic [POS_W-1:0] BEST_POS,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int unsigned TMax = (SETTLE_CYC > ADC_TIMEOUT) ? SETTLE_CYC : ADC_TIMEOUT;
  localparam int unsigned TW   = $clog2(TMax + 1);
  localparam int unsigned CmpW = DW - LSB_IGN;

  state_e           state_q;
  logic [POS_W-1:0] servo_q;
  logic [POS_W-1:0] best_q;
  logic [DW-1:0]    max_q;
  logic [DW-1:0]    pv_q;
  logic             adc_req_q;
  logic             gt_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;

  logic [POS_W:0]   next_pos;
  logic             last_step;
  logic [CmpW-1:0]  adc_m;
  logic [CmpW-1:0]  max_m;
  logic             adc_gt;

  // One extra bit so the step past POS_MAX can never wrap back into range.
  assign next_pos  = {1'b0, servo_q} + (POS_W + 1)'(POS_STEP);
  assign last_step = next_pos > (POS_W + 1)'(POS_MAX);

  assign adc_m  = ADC_DATA[DW-1:LSB_IGN];
  assign max_m  = max_q[DW-1:LSB_IGN];
  assign adc_gt = adc_m > max_m;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state_q)
      StMove, StReturn: begin
        tmr_load = 1'b1;
        tmr_val  = TW'(SETTLE_CYC - 1);
      end
      StReq: begin
        tmr_load = 1'b1;
        tmr_val  = TW'(ADC_TIMEOUT - 1);
      end
      StSettle, StRsettle, StWait: tmr_dec = 1'b1;
      default: ;
    endcase
  end

  sweep_timer #(
    .W (TW)
  ) u_timer (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      servo_q   <= POS_W'(POS_MIN);
      best_q    <= POS_W'(POS_MIN);
      max_q     <= '0;
      pv_q      <= '0;
      adc_req_q <= 1'b0;
      gt_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      adc_req_q <= 1'b0;
      gt_q      <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (START) begin
            servo_q <= POS_W'(POS_MIN);
            best_q  <= POS_W'(POS_MIN);
            max_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StMove;
          end
        end
        StMove: state_q <= StSettle;
        StSettle: begin
          if (tmr_zero) begin
            adc_req_q <= 1'b1;
            state_q   <= StReq;
          end
        end
        StReq: state_q <= StWait;
        StWait: begin
          // The compare result is registered here so GT lines up with CMP.
          if (ADC_VALID) begin
            gt_q    <= adc_gt;
            if (adc_gt) pv_q <= ADC_DATA;
            state_q <= StCmp;
          end else if (tmr_zero) begin
            err_q <= 1'b1;
            if (last_step) begin
              state_q <= StReturn;
            end else begin
              servo_q <= next_pos[POS_W-1:0];
              state_q <= StMove;
            end
          end
        end
        StCmp: begin
          if (gt_q) begin
            max_q  <= pv_q;
            best_q <= servo_q;
          end
          if (last_step) begin
            state_q <= StReturn;
          end else begin
            servo_q <= next_pos[POS_W-1:0];
            state_q <= StMove;
          end
        end
        StReturn: begin
          servo_q <= best_q;
          state_q <= StRsettle;
        end
        StRsettle: begin
          if (tmr_zero) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StFin;
          end
        end
        StFin: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ADC_REQ   = adc_req_q;
  assign SERVO_POS = servo_q;
  assign GT        = gt_q;
  assign PV        = pv_q;
  assign MAX_V     = max_q;
  assign BEST_POS  = best_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_sweep_peak_ctrl.sv
// Randomized bench for sweep_peak_ctrl against a sweep-level peak model; a second
// instance uses a limit that is not on a step boundary.
module tb_sweep_peak_ctrl;

  localparam int unsigned DW      = 12;
  localparam int unsigned POS_W   = 8;
  localparam int          PMIN    = 0;
  localparam int          PMAX    = 40;
  localparam int          PMAX_NA = 35;
  localparam int          PSTEP   = 10;
  localparam int          SETTLE  = 4;
  localparam int          TOUT    = 8;
  localparam int          LSB     = 2;
  localparam int          NPTS    = 5;
  localparam int          NPTS_NA = 4;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             START = 1'b0;
  logic [DW-1:0]    adc_data = '0;
  logic             adc_valid = 1'b0;
  logic [DW-1:0]    adc_data_n = '0;
  logic             adc_valid_n = 1'b0;

  logic             adc_req, gt, busy, done, err;
  logic [POS_W-1:0] servo_pos, best_pos;
  logic [DW-1:0]    pv, max_v;
  logic             adc_req_n, gt_n, busy_n, done_n, err_n;
  logic [POS_W-1:0] servo_n, best_n;
  logic [DW-1:0]    pv_n, max_n;

  sweep_peak_ctrl #(
    .DW(DW), .POS_W(POS_W), .POS_MIN(PMIN), .POS_MAX(PMAX), .POS_STEP(PSTEP),
    .SETTLE_CYC(SETTLE), .ADC_TIMEOUT(TOUT), .LSB_IGN(LSB)
  ) u_dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ADC_DATA(adc_data), .ADC_VALID(adc_valid),
    .ADC_REQ(adc_req), .SERVO_POS(servo_pos), .GT(gt), .PV(pv), .MAX_V(max_v),
    .BEST_POS(best_pos), .BUSY(busy), .DONE(done), .ERR(err)
  );

  sweep_peak_ctrl #(
    .DW(DW), .POS_W(POS_W), .POS_MIN(PMIN), .POS_MAX(PMAX_NA), .POS_STEP(PSTEP),
    .SETTLE_CYC(SETTLE), .ADC_TIMEOUT(TOUT), .LSB_IGN(LSB)
  ) u_dut_na (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ADC_DATA(adc_data_n), .ADC_VALID(adc_valid_n),
    .ADC_REQ(adc_req_n), .SERVO_POS(servo_n), .GT(gt_n), .PV(pv_n), .MAX_V(max_n),
    .BEST_POS(best_n), .BUSY(busy_n), .DONE(done_n), .ERR(err_n)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus for the main instance and its sweep-level expectations.
  int vals[NPTS];
  bit wh[NPTS];
  int lat;
  int exp_pos[NPTS];
  bit exp_err_at[NPTS];
  int exp_gt[$];
  int exp_max, exp_best;
  bit exp_err;
  bit sweep_on = 1'b0;
  int req_idx, gt_idx, pending, pend_val;
  int done_cnt = 0;
  int cyc = 0;
  int tmo_cyc = 0;
  logic err_prev = 1'b0;

  // Non-aligned instance: samples are drawn when requested, model updated alongside.
  bit na_on = 1'b0;
  int na_idx, na_max, na_best, na_pending, na_val;
  int na_done_cnt = 0;

  function automatic void build_model();
    int m;
    int k;
    m = 0;
    k = 0;
    exp_best = PMIN;
    exp_err = 1'b0;
    exp_gt.delete();
    for (int p = PMIN; p <= PMAX; p += PSTEP) begin
      exp_pos[k] = p;
      exp_err_at[k] = exp_err;
      if (wh[k]) exp_err = 1'b1;
      else if ((vals[k] >> LSB) > (m >> LSB)) begin
        m = vals[k];
        exp_best = p;
        exp_gt.push_back(vals[k]);
      end
      k++;
    end
    exp_max = m;
  endfunction

  // Main instance: ADC responder plus per-cycle comparison.
  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      adc_valid = 1'b0;
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          adc_valid = 1'b1;
          adc_data = DW'(pend_val);
        end
      end
      if (RST_N) begin
        chk("servo_in_range", int'(servo_pos <= PMAX), 1);
        if (gt && !sweep_on) chk("gt_outside_sweep", 1, 0);
        if (adc_req) begin
          if (!sweep_on || req_idx >= NPTS) chk("unexpected_adc_req", 1, 0);
          else begin
            chk("req_pos", int'(servo_pos), exp_pos[req_idx]);
            chk("req_err", int'(err), int'(exp_err_at[req_idx]));
            if (wh[req_idx]) tmo_cyc = cyc;
            else begin
              pending = lat;
              pend_val = vals[req_idx];
            end
            req_idx++;
          end
        end
        if (gt && sweep_on) begin
          if (gt_idx >= exp_gt.size()) chk("unexpected_gt", 1, 0);
          else begin
            chk("gt_pv", int'(pv), exp_gt[gt_idx]);
            gt_idx++;
          end
        end
        if (err && !err_prev && sweep_on)
          chk("err_delay_window", int'((cyc - tmo_cyc) inside {[TOUT:TOUT+2]}), 1);
        if (done) begin
          if (!sweep_on) chk("unexpected_done", 1, 0);
          else begin
            chk("done_req_count", req_idx, NPTS);
            chk("done_gt_count", gt_idx, exp_gt.size());
            chk("done_max_v", int'(max_v), exp_max);
            chk("done_best_pos", int'(best_pos), exp_best);
            chk("done_servo_at_best", int'(servo_pos), exp_best);
            chk("done_err", int'(err), int'(exp_err));
            chk("done_busy_low", int'(busy), 0);
            done_cnt++;
            sweep_on = 1'b0;
          end
        end
      end
      err_prev = err;
    end
  end

  // Non-aligned instance: responder and comparison.
  initial begin
    forever begin
      @(negedge CLK);
      adc_valid_n = 1'b0;
      if (na_pending > 0) begin
        na_pending--;
        if (na_pending == 0) begin
          adc_valid_n = 1'b1;
          adc_data_n = DW'(na_val);
        end
      end
      if (RST_N) begin
        chk("na_servo_in_range", int'(servo_n <= PMAX_NA), 1);
        if (adc_req_n) begin
          if (!na_on || na_idx >= NPTS_NA) chk("na_unexpected_adc_req", 1, 0);
          else begin
            chk("na_req_pos", int'(servo_n), PMIN + na_idx * PSTEP);
            na_val = int'($urandom_range(0, 4095));
            if ((na_val >> LSB) > (na_max >> LSB)) begin
              na_max = na_val;
              na_best = PMIN + na_idx * PSTEP;
            end
            na_pending = 2;
            na_idx++;
          end
        end
        if (done_n) begin
          if (!na_on) chk("na_unexpected_done", 1, 0);
          else begin
            chk("na_done_req_count", na_idx, NPTS_NA);
            chk("na_done_max_v", int'(max_n), na_max);
            chk("na_done_best_pos", int'(best_n), na_best);
            chk("na_done_servo", int'(servo_n), na_best);
            na_done_cnt++;
            na_on = 1'b0;
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge CLK);
    #1 START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  task automatic arm_sweep();
    build_model();
    req_idx = 0;
    gt_idx = 0;
    pending = 0;
    sweep_on = 1'b1;
    na_idx = 0;
    na_max = 0;
    na_best = PMIN;
    na_pending = 0;
    na_on = 1'b1;
  endtask

  task automatic run_sweep(input bit extra_start);
    int n;
    arm_sweep();
    chk("busy_before_start", int'(busy), 0);
    pulse_start();
    @(negedge CLK);
    chk("busy_after_start", int'(busy), 1);
    chk("err_cleared_on_start", int'(err), 0);
    if (extra_start) begin
      repeat (20) @(negedge CLK);
      pulse_start();
    end
    n = 0;
    while (sweep_on && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (sweep_on) begin
      chk("sweep_done_in_budget", 0, 1);
      sweep_on = 1'b0;
    end
    repeat (5) @(negedge CLK);
    if (na_on) begin
      chk("na_sweep_done_in_budget", 0, 1);
      na_on = 1'b0;
    end
  endtask

  task automatic set_vals(input int a, input int b, input int c, input int d, input int e);
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d; vals[4] = e;
    for (int i = 0; i < NPTS; i++) wh[i] = 1'b0;
  endtask

  task automatic rand_vals();
    for (int i = 0; i < NPTS; i++) begin
      vals[i] = int'($urandom_range(0, 4095));
      wh[i] = 1'b0;
    end
  endtask

  initial begin
    int exp_dones;
    int n;
    exp_dones = 0;

    // Reset and idle.
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_adc_req", int'(adc_req), 0);
    chk("rst_servo", int'(servo_pos), PMIN);
    chk("rst_max_v", int'(max_v), 0);
    chk("rst_best", int'(best_pos), PMIN);
    chk("rst_pv", int'(pv), 0);
    chk("rst_gt", int'(gt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    n = 0;
    repeat (100) begin
      @(negedge CLK);
      if (adc_req) n++;
    end
    chk("idle_no_adc_req", n, 0);

    // Basic sweep.
    lat = 2;
    set_vals(100, 300, 900, 500, 200);
    run_sweep(1'b0);
    exp_dones++;
    chk("basic_max_v", int'(max_v), 900);
    chk("basic_best_pos", int'(best_pos), 20);
    chk("basic_servo_pos", int'(servo_pos), 20);
    chk("basic_pv", int'(pv), 900);
    chk("basic_done_count", done_cnt, exp_dones);

    // Noise threshold: 803 masks to the same value as 800.
    set_vals(800, 803, 100, 50, 0);
    run_sweep(1'b0);
    exp_dones++;
    chk("noise_max_v", int'(max_v), 800);
    chk("noise_best_pos", int'(best_pos), 0);

    // All samples below the noise floor: nothing is stored.
    set_vals(3, 2, 1, 0, 3);
    run_sweep(1'b0);
    exp_dones++;
    chk("floor_max_v", int'(max_v), 0);
    chk("floor_best_pos", int'(best_pos), 0);

    // Timeout at position 20; the sweep still completes.
    lat = 3;
    rand_vals();
    wh[2] = 1'b1;
    run_sweep(1'b0);
    exp_dones++;
    chk("timeout_err_sticky", int'(err), 1);
    chk("timeout_done_count", done_cnt, exp_dones);

    // Random sweeps, one with a START pulse while busy.
    for (int s = 0; s < 6; s++) begin
      lat = int'($urandom_range(1, 4));
      rand_vals();
      if (s == 2) wh[int'($urandom_range(0, NPTS - 1))] = 1'b1;
      run_sweep(s == 3);
      exp_dones++;
      chk("rand_done_count", done_cnt, exp_dones);
    end
    chk("na_done_count", na_done_cnt, exp_dones);

    // Abort during settle at position 20.
    lat = 2;
    rand_vals();
    arm_sweep();
    pulse_start();
    n = 0;
    while (!(servo_pos == 20 && busy) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk("abort_reached_pos20", int'(servo_pos), 20);
    @(negedge CLK);
    sweep_on = 1'b0;
    na_on = 1'b0;
    RST_N = 1'b0;
    @(negedge CLK);
    chk("abort_servo", int'(servo_pos), PMIN);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_max_v", int'(max_v), 0);
    RST_N = 1'b1;
    repeat (60) @(negedge CLK);
    chk("abort_no_done", done_cnt, exp_dones);

    // Recovery after abort.
    rand_vals();
    run_sweep(1'b0);
    exp_dones++;
    chk("recover_done_count", done_cnt, exp_dones);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/sweep_peak_ctrl.md
Name: sweep_peak_ctrl

Overview:
Sequencer for the max-voltage tracking datapath. On START it steps the panel servo through a position sweep. At each position it waits for the mechanics to settle, then requests one ADC conversion and compares the result against the running maximum. It owns the enable strobe and the value for the max-voltage storage register, returns the servo to the best position, and then reports DONE.

Parameters:
DW, 12, ADC sample width.
POS_W, 8, servo position width.
POS_MIN, 0, first sweep position.
POS_MAX, 180, last sweep position (inclusive limit).
POS_STEP, 10, position increment per step.
SETTLE_CYC, 1000, CLK cycles waited after every servo move.
ADC_TIMEOUT, 255, CLK cycles allowed between ADC_REQ and ADC_VALID.
LSB_IGN, 2, low ADC bits ignored in comparison (noise threshold).

Ports:
CLK  in  1  system clock.
RST_N  in  1  synchronous active-low reset.
START  in  1  one-cycle pulse; starts a sweep; ignored while BUSY.
ADC_DATA  in  DW  conversion result.
ADC_VALID  in  1  one-cycle pulse qualifying ADC_DATA.
ADC_REQ  out  1  one-cycle conversion request.
SERVO_POS  out  POS_W  commanded servo position.
GT  out  1  one-cycle store enable for the max register.
PV  out  DW  value presented with GT.
MAX_V  out  DW  running/final maximum sample.
BEST_POS  out  POS_W  position of MAX_V.
BUSY  out  1  high from the cycle after START until DONE.
DONE  out  1  one-cycle pulse at sweep end.
ERR  out  1  sticky ADC timeout flag; cleared on the next accepted START.

Behaviour:
- Reset (RST_N=0 at a CLK edge) has priority over all other inputs.
  - State goes to IDLE.
  - SERVO_POS=POS_MIN; MAX_V=0; BEST_POS=POS_MIN; PV=0.
  - ADC_REQ=GT=BUSY=DONE=ERR=0.
  - Reset mid-sweep aborts the sweep immediately; no DONE is issued.
- States: IDLE, MOVE, SETTLE, REQ, WAIT, CMP, RETURN, RSETTLE, FIN.
- IDLE: on START go to MOVE.
  - Load SERVO_POS=POS_MIN, MAX_V=0, BEST_POS=POS_MIN, ERR=0.
  - BUSY rises on the next cycle.
- MOVE: load the settle counter with SETTLE_CYC-1, then go to SETTLE.
- SETTLE: decrement the counter; at 0 go to REQ.
- REQ: ADC_REQ=1 for exactly one cycle, load the timeout counter, then go to WAIT.
- WAIT:
  - ADC_VALID=1: capture ADC_DATA and go to CMP.
  - Timeout expires first: set ERR, treat the sample as not-greater, and go to the step decision.
  - ADC_VALID outside WAIT is ignored.
- CMP: the sample is greater when (ADC_DATA>>LSB_IGN) > (MAX_V>>LSB_IGN).
  - If greater: MAX_V<=ADC_DATA, BEST_POS<=SERVO_POS, and GT=1 with PV=ADC_DATA for one cycle.
  - Ties keep the earlier position.
  - The first valid sample always wins only if it is above 0 after masking.
- Step decision (end of CMP or timeout):
  - If SERVO_POS+POS_STEP > POS_MAX: go to RETURN.
  - Otherwise SERVO_POS += POS_STEP and go to MOVE.
  - Compute the sum at POS_W+1 bits so no wrap-around occurs.
  - POS_MAX itself is sampled only if it is reachable on a step boundary.
- RETURN: SERVO_POS<=BEST_POS, load the settle counter, then go to RSETTLE.
- RSETTLE: count down, then go to FIN.
- FIN: DONE=1 for one cycle, BUSY=0, back to IDLE. MAX_V and BEST_POS hold until the next START.
- Latency per point: 1 (MOVE) + SETTLE_CYC + 1 (REQ) + ADC latency + 1 (CMP).
- START while BUSY is ignored. START in the same cycle as FIN is ignored; it is accepted from IDLE.
- GT is never asserted outside CMP. PV holds its last value between strobes.

Decomposition:
- Shared package sweep_pkg holds:
  - the state enum localparams;
  - DW and POS_W defaults;
  - the masked-compare width constant.
- One natural sub-module: sweep_timer.
  - Loadable down-counter with a zero flag.
  - Reused for the settle and timeout counts.
  - Counter width is clog2 of max(SETTLE_CYC, ADC_TIMEOUT)+1.

Test Plan:
- Reset/idle: hold RST_N=0 for 3 cycles, then release -> all outputs at reset values; no ADC_REQ for 100 cycles without START.
- Basic sweep: POS_MIN=0, POS_MAX=40, POS_STEP=10, SETTLE_CYC=4; ADC returns 100, 300, 900, 500, 200 with 2-cycle latency ->
  - 5 ADC_REQ pulses;
  - GT pulses with PV=100, 300, 900;
  - final SERVO_POS=20, BEST_POS=20, MAX_V=900;
  - DONE is one pulse.
- Noise threshold: LSB_IGN=2, samples 800 then 803 -> no GT for 803 (masked 200 == 200); BEST_POS stays at the first position.
- Timeout: withhold ADC_VALID at position 20 with ADC_TIMEOUT=8 -> ERR=1 after 8 cycles, the sweep continues to 30 and 40, and DONE still fires. ERR clears on the next START.
- Non-aligned limit: POS_MAX=35, POS_STEP=10 -> samples at 0, 10, 20, 30 only; no position beyond 35 is ever driven.
- Abort/re-start: assert RST_N=0 during SETTLE at position 20 -> next cycle is IDLE with SERVO_POS=0 and no DONE. A START pulse during BUSY is ignored: exactly one DONE per accepted START.
